// File: rtl/cbuf_pkg.sv
// Shared types and constants for the CBUF trigger/address controller.
// Every entry in the trigger queue uses the same record layout.
package cbuf_pkg;

   localparam int CBUF_ADDR_W     = 12;
   localparam int BURST_W         = 12;
   localparam int CNT_W           = 32;
   localparam int FIFO_DEPTH      = 4;
   localparam int WORDS_PER_BURST = 4;
   localparam int POST_W          = BURST_W + 2;
   localparam int FIFO_PTR_W      = $clog2(FIFO_DEPTH);
   localparam int FIFO_CNT_W      = FIFO_PTR_W + 1;

   typedef struct packed {
      logic [CBUF_ADDR_W-1:0] start;
      logic [CNT_W-1:0]       tcount;
      logic [POST_W-1:0]      post;
      logic [BURST_W-1:0]     bursts;
   } trig_entry_t;

   // Number of words still to be written after the trigger, clamped at zero
   function automatic logic [POST_W-1:0] calc_post(input logic [BURST_W-1:0] bursts,
                                                   input logic [CBUF_ADDR_W-1:0] pre);
      logic [POST_W-1:0] words;
      logic [POST_W-1:0] pre_ext;
      words   = {bursts, 2'b00};
      pre_ext = POST_W'(pre);
      if (words > pre_ext) begin
         return words - pre_ext;
      end else begin
         return POST_W'(0);
      end
   endfunction

endpackage

// File: rtl/trig_addr_fifo.sv
// First-word-fall-through queue of trigger entries.
// A push into a full queue is accepted only when a pop frees a slot on the same edge.
module trig_addr_fifo
   import cbuf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  trig_entry_t           din,
   output trig_entry_t           dout,
   output logic [FIFO_CNT_W-1:0] count,
   output logic                  full,
   output logic                  empty
);

   trig_entry_t           mem_r [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr_r;
   logic [FIFO_PTR_W-1:0] rd_ptr_r;
   logic [FIFO_CNT_W-1:0] count_r;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   assign full      = (count_r == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty     = (count_r == FIFO_CNT_W'(0));
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop);

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + FIFO_PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
            2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/cbuf_trig_addr_ctrl.sv
// CBUF write pointer, trigger queueing with post-trigger window release,
// read-address generation and burst countdown for one ADC channel.
module cbuf_trig_addr_ctrl
   import cbuf_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   adc_wr_en,
   input  logic                   acq_trig_pulse,
   input  logic [CBUF_ADDR_W-1:0] pretrig_words,
   input  logic [BURST_W-1:0]     burst_count,
   input  logic                   init_circ_buf_rd_addr,
   input  logic                   inc_circ_buf_rd_addr,
   input  logic                   trig_addr_rd_en,
   input  logic                   burst_cntr_init,
   input  logic                   burst_cntr_en,
   input  logic                   err_clr,
   output logic [CBUF_ADDR_W-1:0] circ_buf_wr_addr,
   output logic [CBUF_ADDR_W-1:0] circ_buf_rd_addr,
   output logic                   trig_addr_valid,
   output logic [2:0]             trig_fifo_count,
   output logic                   burst_cntr_zero,
   output logic                   trig_overflow,
   output logic                   seq_err
);

   logic [CBUF_ADDR_W-1:0] wr_addr_r;
   logic [CNT_W-1:0]       wr_count_r;
   logic [CBUF_ADDR_W-1:0] rd_addr_r;
   logic [BURST_W-1:0]     burst_cnt_r;
   logic                   zero_r;
   logic                   valid_r;
   logic                   ovf_r;
   logic                   seq_r;

   trig_entry_t            push_entry_s;
   trig_entry_t            head_s;
   logic [FIFO_CNT_W-1:0]  fifo_count_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;
   logic [CNT_W-1:0]       elapsed_s;
   logic                   window_done_s;
   logic [CBUF_ADDR_W-1:0] rd_next_s;
   logic [BURST_W-1:0]     burst_next_s;
   logic                   ovf_set_s;
   logic                   seq_set_s;

   trig_addr_fifo u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (acq_trig_pulse),
      .pop     (trig_addr_rd_en),
      .din     (push_entry_s),
      .dout    (head_s),
      .count   (fifo_count_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // New queue entry captured from the current write position
   always_comb begin
      push_entry_s.start  = wr_addr_r - pretrig_words;
      push_entry_s.tcount = wr_count_r;
      push_entry_s.post   = calc_post(burst_count, pretrig_words);
      push_entry_s.bursts = burst_count;
   end

   // Modular subtraction keeps the window test correct across counter wrap
   assign elapsed_s     = wr_count_r - head_s.tcount;
   assign window_done_s = (elapsed_s >= CNT_W'(head_s.post));
   assign ovf_set_s     = acq_trig_pulse && fifo_full_s && !trig_addr_rd_en;
   assign seq_set_s     = (init_circ_buf_rd_addr || trig_addr_rd_en) && fifo_empty_s;

   // Next read address; a load from an empty queue holds the current address
   always_comb begin
      rd_next_s = rd_addr_r;
      if (init_circ_buf_rd_addr) begin
         if (!fifo_empty_s) begin
            rd_next_s = head_s.start;
         end else begin
            rd_next_s = rd_addr_r;
         end
      end else if (inc_circ_buf_rd_addr) begin
         rd_next_s = rd_addr_r + CBUF_ADDR_W'(1);
      end else begin
         rd_next_s = rd_addr_r;
      end
   end

   // Next burst counter value, saturating at zero
   always_comb begin
      burst_next_s = burst_cnt_r;
      if (burst_cntr_init) begin
         if (!fifo_empty_s) begin
            burst_next_s = head_s.bursts;
         end else begin
            burst_next_s = burst_cnt_r;
         end
      end else if (burst_cntr_en && (burst_cnt_r != BURST_W'(0))) begin
         burst_next_s = burst_cnt_r - BURST_W'(1);
      end else begin
         burst_next_s = burst_cnt_r;
      end
   end

   // Write pointer and free-running word count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_addr_r  <= '0;
         wr_count_r <= '0;
      end else if (adc_wr_en) begin
         wr_addr_r  <= wr_addr_r + CBUF_ADDR_W'(1);
         wr_count_r <= wr_count_r + CNT_W'(1);
      end else begin
         wr_addr_r  <= wr_addr_r;
         wr_count_r <= wr_count_r;
      end
   end

   // Registered read address, burst counter, release flag and sticky errors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_addr_r   <= '0;
         burst_cnt_r <= '0;
         zero_r      <= 1'b1;
         valid_r     <= 1'b0;
         ovf_r       <= 1'b0;
         seq_r       <= 1'b0;
      end else begin
         rd_addr_r   <= rd_next_s;
         burst_cnt_r <= burst_next_s;
         zero_r      <= (burst_next_s == BURST_W'(0));
         valid_r     <= !fifo_empty_s && window_done_s;
         ovf_r       <= ovf_set_s || (ovf_r && !err_clr);
         seq_r       <= seq_set_s || (seq_r && !err_clr);
      end
   end

   assign circ_buf_wr_addr = wr_addr_r;
   assign circ_buf_rd_addr = rd_addr_r;
   assign trig_addr_valid  = valid_r;
   assign trig_fifo_count  = fifo_count_s;
   assign burst_cntr_zero  = zero_r;
   assign trig_overflow    = ovf_r;
   assign seq_err          = seq_r;

endmodule

// File: tb/tb_cbuf_trig_addr_ctrl.sv
// Directed vector table, hand-written corner sequences and a random run
// against a queue-based reference model of the trigger/address controller.
module tb_cbuf_trig_addr_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_en, trig, init, inc, rd_en, binit, ben, clr;
   logic [11:0] pre, bc;
   logic [11:0] wr_addr, rd_addr;
   logic        valid, zero, ovf, seq;
   logic [2:0]  cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cbuf_trig_addr_ctrl dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .adc_wr_en             (wr_en),
      .acq_trig_pulse        (trig),
      .pretrig_words         (pre),
      .burst_count           (bc),
      .init_circ_buf_rd_addr (init),
      .inc_circ_buf_rd_addr  (inc),
      .trig_addr_rd_en       (rd_en),
      .burst_cntr_init       (binit),
      .burst_cntr_en         (ben),
      .err_clr               (clr),
      .circ_buf_wr_addr      (wr_addr),
      .circ_buf_rd_addr      (rd_addr),
      .trig_addr_valid       (valid),
      .trig_fifo_count       (cnt),
      .burst_cntr_zero       (zero),
      .trig_overflow         (ovf),
      .seq_err               (seq)
   );

   typedef struct {
      logic        wr, trig;
      logic [11:0] pre, bc;
      logic        init, inc, rd, binit, ben, clr;
      logic [11:0] e_wr, e_rd;
      logic        e_valid;
      logic [2:0]  e_cnt;
      logic        e_zero;
   } vec_t;

   typedef struct {
      int     start;
      longint tcount;
      int     post;
      int     bursts;
   } ent_t;

   // reference model state
   ent_t   mq[$];
   int     m_wr, m_rd, m_bc;
   longint m_cnt;
   bit     m_valid, m_zero, m_ovf, m_seq;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      wr_en = 0; trig = 0; init = 0; inc = 0; rd_en = 0; binit = 0; ben = 0; clr = 0;
      pre = 12'd0; bc = 12'd0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle();
      cyc();
      cyc();
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
   endtask

   function automatic vec_t mk(logic w, logic t, logic [11:0] p, logic [11:0] b,
                               logic i, logic rd, logic bi,
                               logic [11:0] ewr, logic [11:0] erd, logic ev,
                               logic [2:0] ec, logic ez);
      vec_t v;
      v.wr = w; v.trig = t; v.pre = p; v.bc = b; v.init = i; v.inc = 1'b0;
      v.rd = rd; v.binit = bi; v.ben = 1'b0; v.clr = 1'b0;
      v.e_wr = ewr; v.e_rd = erd; v.e_valid = ev; v.e_cnt = ec; v.e_zero = ez;
      return v;
   endfunction

   task automatic m_reset();
      mq.delete();
      m_wr = 0; m_rd = 0; m_bc = 0; m_cnt = 0;
      m_valid = 0; m_zero = 1; m_ovf = 0; m_seq = 0;
   endtask

   // one clock edge of the behavioural model, using the inputs held before the edge
   task automatic m_step();
      ent_t e;
      int   sz;
      bit   vnext, set_seq, set_ovf;
      sz      = mq.size();
      vnext   = (sz > 0) && (((m_cnt - mq[0].tcount) & 64'hFFFF_FFFF) >= longint'(mq[0].post));
      set_seq = (init || rd_en) && (sz == 0);
      set_ovf = 0;
      if (init) begin
         if (sz > 0) m_rd = mq[0].start;
      end else if (inc) begin
         m_rd = (m_rd + 1) % 4096;
      end
      if (binit) begin
         if (sz > 0) m_bc = mq[0].bursts;
      end else if (ben && m_bc > 0) begin
         m_bc--;
      end
      e.start  = (m_wr - int'(pre) + 4096) % 4096;
      e.tcount = m_cnt;
      e.bursts = int'(bc);
      e.post   = 4 * int'(bc) - int'(pre);
      if (e.post < 0) e.post = 0;
      if (rd_en && sz > 0) void'(mq.pop_front());
      if (trig) begin
         if (sz < 4 || rd_en) mq.push_back(e);
         else set_ovf = 1;
      end
      m_ovf   = set_ovf || (m_ovf && !clr);
      m_seq   = set_seq || (m_seq && !clr);
      m_valid = vnext;
      m_zero  = (m_bc == 0);
      if (wr_en) begin
         m_wr  = (m_wr + 1) % 4096;
         m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
      end
   endtask

   task automatic cmp_model();
      chk("rnd_wr_addr", 32'(wr_addr), 32'(m_wr));
      chk("rnd_rd_addr", 32'(rd_addr), 32'(m_rd));
      chk("rnd_valid",   32'(valid),   32'(m_valid));
      chk("rnd_count",   32'(cnt),     32'(mq.size()));
      chk("rnd_zero",    32'(zero),    32'(m_zero));
      chk("rnd_ovf",     32'(ovf),     32'(m_ovf));
      chk("rnd_seq",     32'(seq),     32'(m_seq));
   endtask

   vec_t vt[18];

   initial begin
      logic [11:0] e_rd;
      idle();

      // ---- reset state ----
      do_reset();
      chk("rst_wr", 32'(wr_addr), 32'd0);
      chk("rst_rd", 32'(rd_addr), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_count", 32'(cnt), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_seq", 32'(seq), 32'd0);

      // ---- vector table: window release and first read ----
      for (int i = 0; i < 10; i++)
         vt[i] = mk(1, 0, 12'd0, 12'd0, 0, 0, 0, 12'(i + 1), 12'd0, 0, 3'd0, 1);
      vt[10] = mk(0, 1, 12'd4, 12'd2, 0, 0, 0, 12'd10, 12'd0, 0, 3'd1, 1);
      vt[11] = mk(1, 0, 12'd0, 12'd0, 0, 0, 0, 12'd11, 12'd0, 0, 3'd1, 1);
      vt[12] = mk(1, 0, 12'd0, 12'd0, 0, 0, 0, 12'd12, 12'd0, 0, 3'd1, 1);
      vt[13] = mk(1, 0, 12'd0, 12'd0, 0, 0, 0, 12'd13, 12'd0, 0, 3'd1, 1);
      vt[14] = mk(1, 0, 12'd0, 12'd0, 0, 0, 0, 12'd14, 12'd0, 0, 3'd1, 1);
      vt[15] = mk(0, 0, 12'd0, 12'd0, 0, 0, 0, 12'd14, 12'd0, 1, 3'd1, 1);
      vt[16] = mk(0, 0, 12'd0, 12'd0, 1, 1, 1, 12'd14, 12'd6, 1, 3'd0, 0);
      vt[17] = mk(0, 0, 12'd0, 12'd0, 0, 0, 0, 12'd14, 12'd6, 0, 3'd0, 0);
      for (int i = 0; i < 18; i++) begin
         wr_en = vt[i].wr; trig = vt[i].trig; pre = vt[i].pre; bc = vt[i].bc;
         init = vt[i].init; inc = vt[i].inc; rd_en = vt[i].rd;
         binit = vt[i].binit; ben = vt[i].ben; clr = vt[i].clr;
         cyc();
         chk($sformatf("vec%0d_wr", i), 32'(wr_addr), 32'(vt[i].e_wr));
         chk($sformatf("vec%0d_rd", i), 32'(rd_addr), 32'(vt[i].e_rd));
         chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].e_valid));
         chk($sformatf("vec%0d_count", i), 32'(cnt), 32'(vt[i].e_cnt));
         chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vt[i].e_zero));
      end
      idle();

      // ---- read-address wrap, then empty-queue misuse ----
      do_reset();
      wr_en = 1; cyc(); cyc(); wr_en = 0;
      trig = 1; pre = 12'd8; bc = 12'd1; cyc(); idle();
      init = 1; cyc(); idle();
      chk("wrap_init", 32'(rd_addr), 32'hFFA);
      for (int k = 1; k <= 8; k++) begin
         inc = 1; cyc(); idle();
         e_rd = 12'hFFA + 12'(k);
         chk($sformatf("wrap_inc%0d", k), 32'(rd_addr), 32'(e_rd));
      end
      rd_en = 1; cyc(); idle();
      chk("pop_count", 32'(cnt), 32'd0);
      chk("pop_seq", 32'(seq), 32'd0);
      init = 1; cyc(); idle();
      chk("empty_init_rd", 32'(rd_addr), 32'h002);
      chk("empty_init_seq", 32'(seq), 32'd1);
      clr = 1; cyc(); idle();
      chk("seq_clr", 32'(seq), 32'd0);
      rd_en = 1; cyc(); idle();
      chk("empty_pop_count", 32'(cnt), 32'd0);
      chk("empty_pop_seq", 32'(seq), 32'd1);
      chk("empty_pop_rd", 32'(rd_addr), 32'h002);

      // ---- overflow and full-queue push with pop ----
      do_reset();
      for (int k = 0; k < 5; k++) begin
         trig = 1; bc = 12'd1; cyc();
      end
      idle();
      chk("ovf_count", 32'(cnt), 32'd4);
      chk("ovf_flag", 32'(ovf), 32'd1);
      clr = 1; cyc(); idle();
      chk("ovf_clr", 32'(ovf), 32'd0);
      trig = 1; rd_en = 1; cyc(); idle();
      chk("full_pushpop_count", 32'(cnt), 32'd4);
      chk("full_pushpop_ovf", 32'(ovf), 32'd0);
      trig = 1; clr = 1; cyc(); idle();
      chk("set_beats_clr", 32'(ovf), 32'd1);

      // ---- burst countdown ----
      do_reset();
      trig = 1; bc = 12'd3; cyc(); idle();
      trig = 1; bc = 12'd0; cyc(); idle();
      init = 1; rd_en = 1; binit = 1; cyc(); idle();
      chk("burst_init_zero", 32'(zero), 32'd0);
      for (int k = 0; k < 4; k++) begin
         ben = 1; cyc(); idle();
         chk($sformatf("burst_en%0d", k), 32'(zero), (k >= 2) ? 32'd1 : 32'd0);
      end
      binit = 1; rd_en = 1; cyc(); idle();
      chk("burst_zero_load", 32'(zero), 32'd1);

      // ---- asynchronous reset mid-operation ----
      do_reset();
      wr_en = 1; trig = 1; pre = 12'd1; bc = 12'd5; cyc(); cyc();
      idle();
      init = 1; binit = 1; cyc(); idle();
      cyc();
      chk("pre_async_count", 32'(cnt), 32'd2);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_count", 32'(cnt), 32'd0);
      chk("async_wr", 32'(wr_addr), 32'd0);
      chk("async_rd", 32'(rd_addr), 32'd0);
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_zero", 32'(zero), 32'd1);

      // ---- random run against the reference model ----
      do_reset();
      m_reset();
      for (int n = 0; n < 3000; n++) begin
         wr_en = ($urandom_range(0, 9) < 8);
         trig  = ($urandom_range(0, 19) == 0);
         pre   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 40));
         bc    = 12'($urandom_range(0, 12));
         init  = ($urandom_range(0, 9) == 0);
         inc   = ($urandom_range(0, 2) == 0);
         rd_en = ($urandom_range(0, 11) == 0);
         binit = ($urandom_range(0, 9) == 0);
         ben   = ($urandom_range(0, 2) == 0);
         clr   = ($urandom_range(0, 19) == 0);
         @(posedge clk);
         m_step();
         #1;
         cmp_model();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
